xlr8_dm_arb: RTL



---
 rtl/xlr8_dm_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/xlr8_dm_arb.sv
// xlr8_dm_arb: AVR data memory shared by the core port and a lower-priority XB requester port.
// Optional even-parity protection of the array is built in when XLR8_DM_PARITY_EN is defined.
module xlr8_dm_arb #(
    parameter int DM_SIZE  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        cp2,
    input  logic        rst,
    input  logic        core_ce,
    input  logic [15:0] core_addr,
    input  logic        core_we,
    input  logic [7:0]  core_din,
    output logic [7:0]  core_dout,
    output logic        core_wait,
    input  logic        xb_req,
    input  logic [15:0] xb_addr,
    input  logic        xb_we,
    input  logic [7:0]  xb_din,
    output logic        xb_gnt,
    output logic        xb_rvalid,
    output logic [7:0]  xb_dout,
    output logic        par_err,
    output logic [15:0] par_err_addr
);
    localparam int DEPTH = DM_SIZE * 1024;
    localparam int AW    = $clog2(DEPTH);
`ifdef XLR8_DM_PARITY_EN
    localparam int MW    = 9;
`else
    localparam int MW    = 8;
`endif
    localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [MW-1:0] mem_q [DEPTH];

    logic          coreWait_q, coreWait_d;
    logic [7:0]    waitCnt_q, waitCnt_d;
    logic [7:0]    coreDout_q, xbDout_q;
    logic          xbRvalid_q;

    logic          coreWaitEff, coreAct, xbGntInt;
    logic          accEn, accWe, accInRange;
    logic [15:0]   accAddr;
    logic [7:0]    accDin, rdByte;
    logic [AW-1:0] accIdx;
    logic [MW-1:0] rdWord, wrWord;

    // Core always wins the single array slot unless a forced wait cycle hands it to XB.
    assign coreWaitEff = coreWait_q & ~rst;
    assign coreAct     = core_ce & ~coreWaitEff & ~rst;
    assign xbGntInt    = xb_req & ~rst & (~core_ce | coreWaitEff);
    assign accEn       = coreAct | xbGntInt;

    assign accAddr     = coreAct ? core_addr : xb_addr;
    assign accWe       = coreAct ? core_we   : xb_we;
    assign accDin      = coreAct ? core_din  : xb_din;
    assign accInRange  = {1'b0, accAddr} < DEPTH_L;
    assign accIdx      = accAddr[AW-1:0];
    assign rdWord      = mem_q[accIdx];
    assign rdByte      = accInRange ? rdWord[7:0] : 8'h00;

`ifdef XLR8_DM_PARITY_EN
    assign wrWord = {^accDin, accDin};
`else
    assign wrWord = accDin;
`endif

    // Array has no reset so its contents survive rst.
    always_ff @(posedge cp2) begin
        if (accEn && accWe && accInRange) begin
            mem_q[accIdx] <= wrWord;
        end
    end

    // A blocked XB request that has waited MAX_WAIT cycles steals exactly one core cycle.
    always_comb begin
        waitCnt_d  = 8'h00;
        coreWait_d = 1'b0;
        if (xb_req && !xbGntInt && !rst) begin
            if (waitCnt_q == WAIT_LAST) begin
                coreWait_d = 1'b1;
            end else begin
                waitCnt_d = waitCnt_q + 8'h01;
            end
        end
    end

    always_ff @(posedge cp2) begin
        if (rst) begin
            waitCnt_q  <= 8'h00;
            coreWait_q <= 1'b0;
            coreDout_q <= 8'h00;
            xbDout_q   <= 8'h00;
            xbRvalid_q <= 1'b0;
        end else begin
            waitCnt_q  <= waitCnt_d;
            coreWait_q <= coreWait_d;
            xbRvalid_q <= xbGntInt & ~xb_we;
            if (coreAct) begin
                coreDout_q <= core_we ? core_din : rdByte;
            end
            if (xbGntInt && !xb_we) begin
                xbDout_q <= rdByte;
            end
        end
    end

`ifdef XLR8_DM_PARITY_EN
    logic        parErr_q;
    logic [15:0] parErrAddr_q;
    logic        parBad;

    // Stored word holds even parity over all nine bits; only in-range reads are checked.
    assign parBad = accEn & ~accWe & accInRange & (^rdWord);

    always_ff @(posedge cp2) begin
        if (rst) begin
            parErr_q     <= 1'b0;
            parErrAddr_q <= 16'h0000;
        end else if (parBad) begin
            parErr_q <= 1'b1;
            if (!parErr_q) begin
                parErrAddr_q <= accAddr;
            end
        end
    end

    assign par_err      = parErr_q;
    assign par_err_addr = parErrAddr_q;
`else
    assign par_err      = 1'b0;
    assign par_err_addr = 16'h0000;
`endif

    assign core_dout = coreDout_q;
    assign core_wait = coreWaitEff;
    assign xb_gnt    = xbGntInt;
    assign xb_rvalid = xbRvalid_q;
    assign xb_dout   = xbDout_q;

endmodule
